// File: rtl/washing_machine_pkg.sv
// Shared state/selector encodings and default phase lengths for the washing machine controller.
package washing_machine_pkg;

    typedef enum logic [2:0] {
        OFF       = 3'd0,
        IDLE      = 3'd1,
        DELAY     = 3'd2,
        FILLING   = 3'd3,
        WASHING   = 3'd4,
        RINSING   = 3'd5,
        SPINNING  = 3'd6,
        END_CYCLE = 3'd7
    } wm_state_e;

    typedef enum logic [1:0] {
        CYC_QUICK    = 2'b00,
        CYC_NORMAL   = 2'b01,
        CYC_HEAVY    = 2'b10,
        CYC_DELICATE = 2'b11
    } wm_cycle_e;

    typedef enum logic [1:0] {
        SPIN_LOW      = 2'b00,
        SPIN_MEDIUM   = 2'b01,
        SPIN_HIGH     = 2'b10,
        SPIN_HIGH_ALT = 2'b11
    } wm_spin_e;

    localparam logic [7:0] DEF_DELAY_TICKS  = 8'd200;
    localparam logic [7:0] DEF_WASH_TICKS_Q = 8'd40;
    localparam logic [7:0] DEF_WASH_TICKS_N = 8'd80;
    localparam logic [7:0] DEF_WASH_TICKS_H = 8'd120;
    localparam logic [7:0] DEF_WASH_TICKS_D = 8'd30;
    localparam logic [7:0] DEF_RINSE_TICKS  = 8'd50;
    localparam logic [7:0] DEF_SPIN_TICKS_L = 8'd20;
    localparam logic [7:0] DEF_SPIN_TICKS_M = 8'd40;
    localparam logic [7:0] DEF_SPIN_TICKS_H = 8'd60;

endpackage

// File: rtl/wm_phase_timer.sv
// 8-bit loadable down-counter for timed wash phases; clear beats load beats decrement,
// and the decrement saturates at zero.
module wm_phase_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic       dec_i,
    output logic [7:0] count_o,
    output logic       zero_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 8'd0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != 8'd0)) begin
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == 8'd0);

endmodule

// File: rtl/washing_machine_ctrl.sv
// Washing machine sequencer: OFF -> IDLE -> (DELAY) -> FILLING -> WASHING -> RINSING -> SPINNING -> END_CYCLE.
// Optional feature macro WM_UNBALANCE_CHECK_EN: halt the spin and raise alarm while the drum is unbalanced.
module washing_machine_ctrl
    import washing_machine_pkg::*;
#(
    parameter logic [7:0] DELAY_TICKS  = DEF_DELAY_TICKS,
    parameter logic [7:0] WASH_TICKS_Q = DEF_WASH_TICKS_Q,
    parameter logic [7:0] WASH_TICKS_N = DEF_WASH_TICKS_N,
    parameter logic [7:0] WASH_TICKS_H = DEF_WASH_TICKS_H,
    parameter logic [7:0] WASH_TICKS_D = DEF_WASH_TICKS_D,
    parameter logic [7:0] RINSE_TICKS  = DEF_RINSE_TICKS,
    parameter logic [7:0] SPIN_TICKS_L = DEF_SPIN_TICKS_L,
    parameter logic [7:0] SPIN_TICKS_M = DEF_SPIN_TICKS_M,
    parameter logic [7:0] SPIN_TICKS_H = DEF_SPIN_TICKS_H
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       power_button,
    input  logic       start_button,
    input  logic [1:0] cycle_select,
    input  logic [1:0] water_level_select,
    input  logic [1:0] temp_select,
    input  logic [1:0] spin_speed_select,
    input  logic       lid_closed,
    input  logic       water_full,
    input  logic       load_balanced,
    input  logic       delay_start,
    output logic       motor_on,
    output logic       water_pump_on,
    output logic       alarm,
    output logic       door_locked,
    output logic       power_led,
    output logic       cycle_led,
    output logic [7:0] timer,
    output logic       end_of_cycle_alarm
);

    wm_state_e  state_q, state_d;
    logic       power_q, start_q;
    logic [1:0] cycle_sel_q, cycle_sel_d;
    logic [1:0] spin_sel_q, spin_sel_d;
    logic [1:0] water_sel_q, water_sel_d;
    logic [1:0] temp_sel_q, temp_sel_d;

    logic       power_edge, start_edge;
    logic       in_run, paused, spin_hold;
    logic       tmr_clear, tmr_load, tmr_dec, tmr_zero;
    logic [7:0] tmr_val, tmr_count;
    logic [7:0] wash_len, spin_len;

    assign power_edge = power_button & ~power_q;
    assign start_edge = start_button & ~start_q;
    assign in_run     = (state_q == FILLING) || (state_q == WASHING) ||
                        (state_q == RINSING) || (state_q == SPINNING);
    assign paused     = in_run & ~lid_closed;

`ifdef WM_UNBALANCE_CHECK_EN
    assign spin_hold = (state_q == SPINNING) & ~load_balanced;
`else
    logic unused_balance;
    assign spin_hold      = 1'b0;
    assign unused_balance = load_balanced;
`endif

    // Water level and temperature are captured for reporting only.
    logic unused_sel;
    assign unused_sel = ^{water_sel_q, temp_sel_q};

    always_comb begin
        case (wm_cycle_e'(cycle_sel_q))
            CYC_QUICK:  wash_len = WASH_TICKS_Q;
            CYC_NORMAL: wash_len = WASH_TICKS_N;
            CYC_HEAVY:  wash_len = WASH_TICKS_H;
            default:    wash_len = WASH_TICKS_D;
        endcase
        case (wm_spin_e'(spin_sel_q))
            SPIN_LOW:    spin_len = SPIN_TICKS_L;
            SPIN_MEDIUM: spin_len = SPIN_TICKS_M;
            default:     spin_len = SPIN_TICKS_H;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cycle_sel_d = cycle_sel_q;
        spin_sel_d  = spin_sel_q;
        water_sel_d = water_sel_q;
        temp_sel_d  = temp_sel_q;
        tmr_clear   = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = 8'd0;
        tmr_dec     = 1'b0;

        // Power edge overrides everything else, including a simultaneous start.
        if (power_edge) begin
            if (state_q == OFF) begin
                state_d = IDLE;
            end else begin
                state_d   = OFF;
                tmr_clear = 1'b1;
            end
        end else begin
            case (state_q)
                OFF: ;
                IDLE: begin
                    if (start_edge && lid_closed) begin
                        cycle_sel_d = cycle_select;
                        spin_sel_d  = spin_speed_select;
                        water_sel_d = water_level_select;
                        temp_sel_d  = temp_select;
                        if (delay_start) begin
                            state_d  = DELAY;
                            tmr_load = 1'b1;
                            tmr_val  = DELAY_TICKS;
                        end else begin
                            state_d   = FILLING;
                            tmr_clear = 1'b1;
                        end
                    end
                end
                DELAY: begin
                    if (tmr_zero) state_d = FILLING;
                    else          tmr_dec = 1'b1;
                end
                FILLING: begin
                    if (!paused && water_full) begin
                        state_d  = WASHING;
                        tmr_load = 1'b1;
                        tmr_val  = wash_len;
                    end
                end
                WASHING: begin
                    if (!paused) begin
                        if (tmr_zero) begin
                            state_d  = RINSING;
                            tmr_load = 1'b1;
                            tmr_val  = RINSE_TICKS;
                        end else begin
                            tmr_dec = 1'b1;
                        end
                    end
                end
                RINSING: begin
                    if (!paused) begin
                        if (tmr_zero) begin
                            state_d  = SPINNING;
                            tmr_load = 1'b1;
                            tmr_val  = spin_len;
                        end else begin
                            tmr_dec = 1'b1;
                        end
                    end
                end
                SPINNING: begin
                    if (!paused && !spin_hold) begin
                        if (tmr_zero) state_d = END_CYCLE;
                        else          tmr_dec = 1'b1;
                    end
                end
                END_CYCLE: begin
                    if (start_edge || !lid_closed) state_d = IDLE;
                end
                default: state_d = OFF;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= OFF;
            power_q     <= 1'b0;
            start_q     <= 1'b0;
            cycle_sel_q <= 2'b00;
            spin_sel_q  <= 2'b00;
            water_sel_q <= 2'b00;
            temp_sel_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            power_q     <= power_button;
            start_q     <= start_button;
            cycle_sel_q <= cycle_sel_d;
            spin_sel_q  <= spin_sel_d;
            water_sel_q <= water_sel_d;
            temp_sel_q  <= temp_sel_d;
        end
    end

    wm_phase_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (tmr_clear),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .count_o    (tmr_count),
        .zero_o     (tmr_zero)
    );

    // An open lid gates both actuators even though the state itself is held.
    assign motor_on           = lid_closed & ((state_q == WASHING) || (state_q == RINSING) ||
                                              ((state_q == SPINNING) && !spin_hold));
    assign water_pump_on      = lid_closed & ((state_q == FILLING) || (state_q == RINSING));
    assign alarm              = ~lid_closed | spin_hold;
    assign door_locked        = in_run;
    assign power_led          = (state_q != OFF);
    assign cycle_led          = in_run || (state_q == DELAY);
    assign timer              = tmr_count;
    assign end_of_cycle_alarm = (state_q == END_CYCLE);

endmodule

// File: tb/tb_washing_machine_ctrl.sv
// Randomized bench for washing_machine_ctrl with a phase/duration reference model and an output scoreboard.
module tb_washing_machine_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       power_button, start_button;
    logic [1:0] cycle_select, water_level_select, temp_select, spin_speed_select;
    logic       lid_closed, water_full, load_balanced, delay_start;
    logic       motor_on, water_pump_on, alarm, door_locked, power_led, cycle_led, end_of_cycle_alarm;
    logic [7:0] timer;

    always #5 clk = ~clk;

    washing_machine_ctrl dut (
        .clk                (clk),
        .reset              (reset),
        .power_button       (power_button),
        .start_button       (start_button),
        .cycle_select       (cycle_select),
        .water_level_select (water_level_select),
        .temp_select        (temp_select),
        .spin_speed_select  (spin_speed_select),
        .lid_closed         (lid_closed),
        .water_full         (water_full),
        .load_balanced      (load_balanced),
        .delay_start        (delay_start),
        .motor_on           (motor_on),
        .water_pump_on      (water_pump_on),
        .alarm              (alarm),
        .door_locked        (door_locked),
        .power_led          (power_led),
        .cycle_led          (cycle_led),
        .timer              (timer),
        .end_of_cycle_alarm (end_of_cycle_alarm)
    );

    typedef struct {
        logic       motor, pump, alrm, door, pled, cled, eoc;
        logic [7:0] tmr;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: phase number and remaining ticks, in the order the machine runs them.
    localparam int PH_OFF = 0, PH_IDLE = 1, PH_DELAY = 2, PH_FILL = 3,
                   PH_WASH = 4, PH_RINSE = 5, PH_SPIN = 6, PH_END = 7;
    int m_phase, m_ticks, m_cyc, m_spin;
    bit m_pwr_prev, m_start_prev;

    function automatic int wash_len(int c);
        case (c)
            0: return 40;
            1: return 80;
            2: return 120;
            default: return 30;
        endcase
    endfunction

    function automatic int spin_len(int s);
        if (s == 0) return 20;
        if (s == 1) return 40;
        return 60;
    endfunction

    function automatic bit unbalanced_now();
`ifdef WM_UNBALANCE_CHECK_EN
        return (m_phase == PH_SPIN) && !load_balanced;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_phase = PH_OFF; m_ticks = 0; m_cyc = 0; m_spin = 0;
        m_pwr_prev = 1'b0; m_start_prev = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs present at that edge.
    task automatic model_edge();
        bit pwr_ev, start_ev, running, hold;
        pwr_ev   = power_button && !m_pwr_prev;
        start_ev = start_button && !m_start_prev;
        running  = (m_phase >= PH_FILL) && (m_phase <= PH_SPIN);
        hold     = (running && !lid_closed) || unbalanced_now();
        m_pwr_prev   = power_button;
        m_start_prev = start_button;
        if (pwr_ev) begin
            if (m_phase == PH_OFF) m_phase = PH_IDLE;
            else begin m_phase = PH_OFF; m_ticks = 0; end
            return;
        end
        case (m_phase)
            PH_IDLE: if (start_ev && lid_closed) begin
                m_cyc  = int'(cycle_select);
                m_spin = int'(spin_speed_select);
                if (delay_start) begin m_phase = PH_DELAY; m_ticks = 200; end
                else             begin m_phase = PH_FILL;  m_ticks = 0;   end
            end
            PH_DELAY: if (m_ticks == 0) m_phase = PH_FILL; else m_ticks -= 1;
            PH_FILL:  if (!hold && water_full) begin m_phase = PH_WASH; m_ticks = wash_len(m_cyc); end
            PH_WASH, PH_RINSE, PH_SPIN: if (!hold) begin
                if (m_ticks > 0) m_ticks -= 1;
                else begin
                    m_phase += 1;
                    if (m_phase == PH_RINSE)     m_ticks = 50;
                    else if (m_phase == PH_SPIN) m_ticks = spin_len(m_spin);
                    else                         m_ticks = 0;
                end
            end
            PH_END: if (start_ev || !lid_closed) m_phase = PH_IDLE;
            default: ;
        endcase
    endtask

    task automatic expect_now();
        exp_t e;
        bit   running;
        running = (m_phase >= PH_FILL) && (m_phase <= PH_SPIN);
        e.motor = lid_closed && ((m_phase == PH_WASH) || (m_phase == PH_RINSE) ||
                                 ((m_phase == PH_SPIN) && !unbalanced_now()));
        e.pump  = lid_closed && ((m_phase == PH_FILL) || (m_phase == PH_RINSE));
        e.alrm  = !lid_closed || unbalanced_now();
        e.door  = running;
        e.pled  = (m_phase != PH_OFF);
        e.cled  = running || (m_phase == PH_DELAY);
        e.eoc   = (m_phase == PH_END);
        e.tmr   = 8'(m_ticks);
        sb_q.push_back(e);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic hold_cycles(int n);
        repeat (n) begin next(); expect_now(); end
    endtask

    task automatic press_power();
        next(); power_button = 1'b1; expect_now();
        next(); power_button = 1'b0; expect_now();
    endtask

    task automatic press_start();
        next(); start_button = 1'b1; expect_now();
        next(); start_button = 1'b0; expect_now();
    endtask

    task automatic chk(string name, logic [7:0] act, logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("motor_on",           {7'd0, motor_on},           {7'd0, e.motor});
            chk("water_pump_on",      {7'd0, water_pump_on},      {7'd0, e.pump});
            chk("alarm",              {7'd0, alarm},              {7'd0, e.alrm});
            chk("door_locked",        {7'd0, door_locked},        {7'd0, e.door});
            chk("power_led",          {7'd0, power_led},          {7'd0, e.pled});
            chk("cycle_led",          {7'd0, cycle_led},          {7'd0, e.cled});
            chk("end_of_cycle_alarm", {7'd0, end_of_cycle_alarm}, {7'd0, e.eoc});
            chk("timer",              timer,                      e.tmr);
        end
    end

    initial begin
        reset = 1'b1;
        power_button = 1'b0; start_button = 1'b0;
        cycle_select = 2'b01; water_level_select = 2'b00; temp_select = 2'b00;
        spin_speed_select = 2'b01;
        lid_closed = 1'b0; water_full = 1'b0; load_balanced = 1'b1; delay_start = 1'b0;
        model_reset();

        // Reset with the lid open, then closed.
        #1; expect_now();
        @(negedge clk); #1; lid_closed = 1'b1; expect_now();
        @(negedge clk); #1; reset = 1'b0;

        // Normal cycle, medium spin, lid pause in the wash, then acknowledge.
        press_power();
        press_start();
        hold_cycles(3);
        next(); water_full = 1'b1; expect_now();
        next(); water_full = 1'b0; expect_now();
        hold_cycles(48);
        next(); lid_closed = 1'b0; expect_now();
        hold_cycles(6);
        next(); lid_closed = 1'b1; expect_now();
        hold_cycles(200);
        press_start();
        hold_cycles(2);

        // Abort during rinse.
        press_start();
        next(); water_full = 1'b1; expect_now();
        next(); water_full = 1'b0; expect_now();
        hold_cycles(100);
        press_power();
        hold_cycles(3);

        // High spin with the drum going out of balance mid-spin.
        press_power();
        spin_speed_select = 2'b11; cycle_select = 2'b00;
        press_start();
        next(); water_full = 1'b1; expect_now();
        next(); water_full = 1'b0; expect_now();
        hold_cycles(110);
        next(); load_balanced = 1'b0; expect_now();
        hold_cycles(12);
        next(); load_balanced = 1'b1; expect_now();
        hold_cycles(80);

        // Simultaneous power and start edges from END_CYCLE or IDLE.
        next(); power_button = 1'b1; start_button = 1'b1; expect_now();
        next(); power_button = 1'b0; start_button = 1'b0; expect_now();
        hold_cycles(2);

        // Randomized operation.
        for (int i = 0; i < 20000; i++) begin
            next();
            power_button       = ($urandom_range(0, 999) < 4);
            start_button       = ($urandom_range(0, 99) < 6);
            cycle_select       = 2'($urandom_range(0, 3));
            spin_speed_select  = 2'($urandom_range(0, 3));
            water_level_select = 2'($urandom_range(0, 3));
            temp_select        = 2'($urandom_range(0, 3));
            lid_closed         = ($urandom_range(0, 99) < 94);
            water_full         = ($urandom_range(0, 99) < 8);
            load_balanced      = ($urandom_range(0, 99) < 88);
            delay_start        = ($urandom_range(0, 99) < 25);
            expect_now();
        end

        @(negedge clk); #1;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/washing_machine_ctrl.md
# washing_machine_ctrl

Top-level sequencer for a domestic washing machine. Takes front-panel buttons, option selectors and the lid, water-level and load-balance sensors, and drives the motor, water pump, door lock, status LEDs, alarms and an 8-bit phase countdown. Runs OFF → IDLE → (DELAY) → FILLING → WASHING → RINSING → SPINNING → END_CYCLE.

## Interface
- Clock `clk`; reset `reset`: one clock, asynchronous, active-high.
- `DELAY_TICKS`, default 8'd200: DELAY phase length in clocks.
- `WASH_TICKS_Q/N/H/D`, defaults 8'd40/8'd80/8'd120/8'd30: WASHING length for cycle_select 00/01/10/11.
- `RINSE_TICKS`, default 8'd50: RINSING length.
- `SPIN_TICKS_L/M/H`, defaults 8'd20/8'd40/8'd60: SPINNING length for spin_speed_select 00/01/(10,11).
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous active-high reset
- power_button  in  1  power toggle, rising-edge detected
- start_button  in  1  start/acknowledge, rising-edge detected
- cycle_select  in  2  00 quick, 01 normal, 10 heavy, 11 delicate
- water_level_select  in  2  latched at start; reported only, no control effect
- temp_select  in  2  latched at start; reported only, no control effect
- spin_speed_select  in  2  00 low, 01 medium, 10/11 high
- lid_closed  in  1  1 = lid closed
- water_full  in  1  level sensor, 1 = target level reached
- load_balanced  in  1  1 = drum balanced
- delay_start  in  1  1 = insert DELAY phase before FILLING
- motor_on  out  1  drum motor enable
- water_pump_on  out  1  inlet pump enable
- alarm  out  1  fault alarm
- door_locked  out  1  door lock solenoid
- power_led  out  1  1 whenever state ≠ OFF
- cycle_led  out  1  1 in DELAY through SPINNING
- timer  out  8  remaining ticks in current timed phase, else 0
- end_of_cycle_alarm  out  1  1 in END_CYCLE

## Operation
- Reset: state OFF, timer 0, edge-detect registers 0, latched selectors 0. All outputs 0 except alarm = ~lid_closed.
- alarm = ~lid_closed in every state, including OFF and during reset; plus the unbalance term (Configuration).
- power_button edge: OFF → IDLE; any other state → OFF, abort, timer 0.
- IDLE: start edge with lid_closed=1 latches selectors and loads timer. Goes to DELAY if delay_start=1, else FILLING. Start with lid open is ignored.
- DELAY: counts down DELAY_TICKS, then FILLING.
- FILLING: water_pump_on=1; timer held 0. water_full=1 → WASHING, timer ← WASH_TICKS for the latched cycle.
- WASHING: motor_on=1. Timer 0 → RINSING, timer ← RINSE_TICKS.
- RINSING: motor_on=1, water_pump_on=1. Timer 0 → SPINNING, timer ← SPIN_TICKS for the latched speed.
- SPINNING: motor_on=1. Timer 0 → END_CYCLE.
- END_CYCLE: end_of_cycle_alarm=1, door unlocked. Start edge or lid_closed=0 → IDLE.
- door_locked=1 in FILLING, WASHING, RINSING, SPINNING.
- Lid opened in FILLING..SPINNING: pause. motor_on and water_pump_on forced 0, timer holds, state holds, door stays locked. Resumes when lid closes.
- Timer decrements by 1 per clock in a timed phase, saturating at 0. Transition occurs on the clock where timer==0.
- Simultaneous power and start edges: power wins.

## Timing
- Moore outputs decoded from registered state; alarm is combinational from lid_closed.
- Button edge → state change on the next rising clk.
- Phase with N ticks lasts N+1 clocks: load N, count to 0, transition.
- water_full sampled each clock; a 1-clock pulse suffices.

## Configuration
- `WM_UNBALANCE_CHECK_EN` defined: in SPINNING with load_balanced=0, motor_on=0, timer holds, alarm=1. Resumes when balanced.
- Not defined: load_balanced is ignored.

## Structure
- Package `washing_machine_pkg`: state enum (OFF, IDLE, DELAY, FILLING, WASHING, RINSING, SPINNING, END_CYCLE), cycle and spin-speed select encodings, default tick constants.
- One sub-module `wm_phase_timer`: 8-bit loadable down-counter with hold and zero flag.

## Test plan
- Reset, lid open → all outputs 0, alarm=1; lid closed → alarm=0.
- Power edge, start with delay_start=0, lid closed → FILLING, pump=1, door_locked=1. water_full pulse → WASHING, motor=1, timer=80 (normal).
- Full normal cycle with defaults → END_CYCLE after 81+51+41 clocks from water_full, end_of_cycle_alarm=1. Start edge → IDLE.
- Lid opened mid-WASHING at timer=30 → motor=0, alarm=1, timer stays 30. Lid closed → resumes at 30.
- Power edge during RINSING → OFF; all outputs 0 next clock.
- With `WM_UNBALANCE_CHECK_EN`, load_balanced=0 in SPINNING → motor=0, alarm=1, timer frozen. Without the macro, spin completes.
